// File: rtl/led_seg_scan.sv
// Eight-digit multiplexed hex display for a 32-bit word, with a blank gap between digit slots and tear-free updates at frame wrap.
// Optional macro LEADING_ZERO_BLANK_EN: keep leading zero digits (idx>0) dark while still scanning them.
module led_seg_scan #(
    parameter int CLK_DIV        = 50000,
    parameter int GAP_CYC        = 500,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in,
    input  logic        load,
    input  logic [7:0]  dp_mask,
    output logic [7:0]  an,
    output logic [7:0]  seg,
    output logic        frame
);
    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [7:0] OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

    typedef enum logic [1:0] {IDLE, GAP, SHOW} state_t;

    state_t      state, state_n;
    logic [2:0]  idx, idx_n;
    logic [CW-1:0] div_cnt, div_cnt_n;
    logic [31:0] shadow, shadow_n;
    logic [31:0] pend, pend_n;
    logic        pend_v, pend_v_n;
    logic        frame_n, wrap;
    logic [7:0]  an_hi, seg_hi, an_n, seg_n;
    logic [3:0]  nib;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
        endcase
    endfunction

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        div_cnt_n = div_cnt;
        shadow_n  = shadow;
        pend_n    = pend;
        pend_v_n  = pend_v;
        wrap      = 1'b0;
        case (state)
            IDLE: if (load) begin
                shadow_n  = data_in;
                idx_n     = 3'd0;
                div_cnt_n = '0;
                state_n   = GAP;
            end
            GAP: begin
                div_cnt_n = div_cnt + 1'b1;
                if (div_cnt == CW'(GAP_CYC - 1)) state_n = SHOW;
            end
            SHOW: begin
                if (div_cnt == CW'(CLK_DIV - 1)) begin
                    div_cnt_n = '0;
                    idx_n     = idx + 3'd1;
                    state_n   = GAP;
                    wrap      = (idx == 3'd7);
                end else begin
                    div_cnt_n = div_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        // Loads while scanning are parked until the frame wraps.
        if (state != IDLE && load) begin
            pend_n   = data_in;
            pend_v_n = 1'b1;
        end
        if (wrap) begin
            if (load) begin
                shadow_n = data_in;
                pend_v_n = 1'b0;
            end else if (pend_v) begin
                shadow_n = pend;
                pend_v_n = 1'b0;
            end
        end
        frame_n = wrap;
    end

    // Outputs are built from next-state values so they land with the state register.
    always_comb begin
        nib    = shadow_n[{idx_n, 2'b00} +: 4];
        an_hi  = 8'h00;
        seg_hi = {dp_mask[idx_n], hex7(nib)};
        case (state_n)
            IDLE: seg_hi = 8'h00;
            SHOW: begin
                an_hi = 8'h01 << idx_n;
`ifdef LEADING_ZERO_BLANK_EN
                if (idx_n != 3'd0 && (shadow_n >> {idx_n, 2'b00}) == 32'd0) an_hi = 8'h00;
`endif
            end
            default: an_hi = 8'h00;
        endcase
        an_n  = an_hi ^ OFF;
        seg_n = seg_hi ^ OFF;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            idx     <= 3'd0;
            div_cnt <= '0;
            shadow  <= 32'd0;
            pend    <= 32'd0;
            pend_v  <= 1'b0;
            an      <= OFF;
            seg     <= OFF;
            frame   <= 1'b0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            div_cnt <= div_cnt_n;
            shadow  <= shadow_n;
            pend    <= pend_n;
            pend_v  <= pend_v_n;
            an      <= an_n;
            seg     <= seg_n;
            frame   <= frame_n;
        end
    end
endmodule

// File: tb/tb_led_seg_scan.sv
// Directed bench for led_seg_scan with CLK_DIV=8, GAP_CYC=2, active-low outputs.
// Builds with LEADING_ZERO_BLANK_EN add the leading-zero blanking steps.
module tb_led_seg_scan;
    localparam int CLK_DIV = 8;
    localparam int GAP_CYC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic [31:0] data_in = 32'd0;
    logic [7:0]  dp_mask = 8'd0;
    logic [7:0]  an, seg;
    logic        frame;

    int n_cmp = 0;
    int n_err = 0;

    // Active-low segment codes for 32'h12345678 and 32'hDEADBEEF, digit 0 first.
    logic [7:0] tbl_old [8] = '{8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
    logic [7:0] tbl_new [8] = '{8'h8E, 8'h86, 8'h86, 8'h83, 8'hA1, 8'h88, 8'h86, 8'hA1};

    always #5 clk = ~clk;

    led_seg_scan #(.CLK_DIV(CLK_DIV), .GAP_CYC(GAP_CYC), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .load(load),
        .dp_mask(dp_mask), .an(an), .seg(seg), .frame(frame)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // t = cycles since the load edge (1-based); digit seg is expected in gap and show.
    task automatic slot_chk(input int t, input logic [7:0] dseg);
        int s, p;
        logic [7:0] ea;
        s  = ((t - 1) / CLK_DIV) % 8;
        p  = (t - 1) % CLK_DIV;
        ea = (p < GAP_CYC) ? 8'hFF : ~(8'h01 << s);
        chk($sformatf("an_t%0d", t), an, ea);
        chk($sformatf("seg_t%0d", t), seg, dseg);
    endtask

    task automatic blank_chk(input string tag);
        chk({tag, "_an"}, an, 8'hFF);
        chk({tag, "_seg"}, seg, 8'hFF);
        chk({tag, "_frame"}, {7'd0, frame}, 8'h00);
    endtask

    initial begin
        int s, p;
        logic fexp;
        // Reset held, then idle without load
        repeat (3) begin @(negedge clk); blank_chk("rst"); end
        rst = 1'b1;
        repeat (100) begin @(negedge clk); blank_chk("idle"); end

        // Basic scan, frame timing, tear-free update mid-frame
        data_in = 32'h12345678; load = 1'b1;
        for (int t = 1; t <= 192; t++) begin
            @(negedge clk);
            if (t == 1) load = 1'b0;
            s = ((t - 1) / CLK_DIV) % 8;
            slot_chk(t, (t <= 128) ? tbl_old[s] : tbl_new[s]);
            fexp = (t > 1) && ((t - 1) % 64 == 0);
            chk($sformatf("frame_t%0d", t), {7'd0, frame}, {7'd0, fexp});
            if (t == 91) begin data_in = 32'hDEADBEEF; load = 1'b1; end
            if (t == 92) load = 1'b0;
        end

        // Queue a pending value, then reset during digit 5 SHOW
        for (int t = 193; t <= 236; t++) begin
            @(negedge clk);
            s = ((t - 1) / CLK_DIV) % 8;
            slot_chk(t, tbl_new[s]);
            chk($sformatf("frame_t%0d", t), {7'd0, frame}, {7'd0, (t == 193)});
            if (t == 200) begin data_in = 32'd0; load = 1'b1; end
            if (t == 201) load = 1'b0;
            if (t == 236) rst = 1'b0;
        end
        @(negedge clk);
        rst = 1'b1;
        blank_chk("midrst");
        repeat (50) begin @(negedge clk); blank_chk("postrst"); end

        // Fresh load with dp on digit 0; discarded pend must not replace it at wrap
        dp_mask = 8'h01; data_in = 32'h00000009; load = 1'b1;
        for (int t = 1; t <= 72; t++) begin
            @(negedge clk);
            if (t == 1) load = 1'b0;
            s = ((t - 1) / CLK_DIV) % 8;
            p = (t - 1) % CLK_DIV;
            if (s == 0 && p >= GAP_CYC) begin
                chk($sformatf("dp_an_t%0d", t), an, 8'hFE);
                chk($sformatf("dp_seg_t%0d", t), seg, 8'h10);
            end
            if (t == 65) chk("dp_frame", {7'd0, frame}, 8'h01);
        end
        dp_mask = 8'h00;

`ifdef LEADING_ZERO_BLANK_EN
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); rst = 1'b0;
            @(negedge clk); rst = 1'b1;
            data_in = (k == 0) ? 32'h000000A5 : 32'h00000000;
            load = 1'b1;
            for (int t = 1; t <= 64; t++) begin
                logic [7:0] ea, es;
                @(negedge clk);
                if (t == 1) load = 1'b0;
                s = ((t - 1) / CLK_DIV) % 8;
                p = (t - 1) % CLK_DIV;
                ea = 8'hFF;
                if (p >= GAP_CYC && s == 0) ea = 8'hFE;
                if (p >= GAP_CYC && s == 1 && k == 0) ea = 8'hFD;
                chk($sformatf("lzb%0d_an_t%0d", k, t), an, ea);
                if (p >= GAP_CYC && s < 2) begin
                    es = (k == 1) ? 8'hC0 : ((s == 0) ? 8'h92 : 8'h88);
                    chk($sformatf("lzb%0d_seg_t%0d", k, t), seg, es);
                end
            end
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
